// File: rtl/sys_arb_pkg.sv
// rtl/sys_arb_pkg.sv - shared types and defaults for the system write-port arbiter
package sys_arb_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DBG,
      S_CPU
   } owner_t;

   typedef enum logic {
      SRC_DBG,
      SRC_CPU
   } src_t;

endpackage

// File: rtl/sys_wr_fifo.sv
// rtl/sys_wr_fifo.sv - synchronous FIFO absorbing fire-and-forget debug writes
// A push while full is taken only when a pop frees the head slot in the same cycle.
module sys_wr_fifo
   import sys_arb_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int W     = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sys_wr_arbiter.sv
// rtl/sys_wr_arbiter.sv - round-robin merge of debug FIFO and CPU writes into one registered slot
// Optional SYS_WR_ARB_DROPCNT_EN adds the saturating drop_count port and counter.
module sys_wr_arbiter
   import sys_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  dbg_wr,
   input  logic [AW-1:0]         dbg_waddr,
   input  logic [DW-1:0]         dbg_wdata,
   input  logic                  cpu_req,
   input  logic [AW-1:0]         cpu_waddr,
   input  logic [DW-1:0]         cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  mem_wr,
   output logic [AW-1:0]         mem_waddr,
   output logic [DW-1:0]         mem_wdata,
   input  logic                  mem_ready,
   input  logic                  ovf_clr,
   output logic                  dbg_overflow,
`ifdef SYS_WR_ARB_DROPCNT_EN
   output logic [7:0]            drop_count,
`endif
   output logic [$clog2(DEPTH):0] dbg_level
);

   owner_t        owner_q, owner_d;
   src_t          last_q, last_d;
   logic          mem_wr_q, mem_wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          ovf_q, ovf_d;

   logic          free, sel_dbg, sel_cpu, drop;
   logic          fifo_full, fifo_empty;
   logic [AW+DW-1:0] fifo_rdata;

   sys_wr_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (dbg_wr),
      .wdata ({dbg_waddr, dbg_wdata}),
      .pop   (sel_dbg),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (dbg_level)
   );

   assign free = ~mem_wr_q | mem_ready;

   // A full FIFO outranks fairness because debug writes cannot be stalled.
   always_comb begin
      sel_dbg = 1'b0;
      sel_cpu = 1'b0;
      if (free) begin
         if (fifo_full) begin
            sel_dbg = 1'b1;
         end else if (!fifo_empty && cpu_req) begin
            if (last_q == SRC_DBG) sel_cpu = 1'b1;
            else                   sel_dbg = 1'b1;
         end else if (!fifo_empty) begin
            sel_dbg = 1'b1;
         end else if (cpu_req) begin
            sel_cpu = 1'b1;
         end
      end
   end

   assign cpu_gnt = sel_cpu & sys_rst_n;
   assign drop    = dbg_wr & fifo_full & ~sel_dbg;

   always_comb begin
      owner_d  = owner_q;
      last_d   = last_q;
      mem_wr_d = mem_wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (free) begin
         if (sel_dbg) begin
            owner_d  = S_DBG;
            last_d   = SRC_DBG;
            mem_wr_d = 1'b1;
            addr_d   = fifo_rdata[AW+DW-1:DW];
            data_d   = fifo_rdata[DW-1:0];
         end else if (sel_cpu) begin
            owner_d  = S_CPU;
            last_d   = SRC_CPU;
            mem_wr_d = 1'b1;
            addr_d   = cpu_waddr;
            data_d   = cpu_wdata;
         end else begin
            owner_d  = S_IDLE;
            mem_wr_d = 1'b0;
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         owner_q  <= S_IDLE;
         last_q   <= SRC_CPU;
         mem_wr_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         mem_wr_q <= mem_wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end

   assign mem_wr       = mem_wr_q;
   assign mem_waddr    = addr_q;
   assign mem_wdata    = data_q;
   assign dbg_overflow = ovf_q;

`ifdef SYS_WR_ARB_DROPCNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                       drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sys_wr_arbiter.sv
// tb/tb_sys_wr_arbiter.sv - self-checking bench for sys_wr_arbiter
module tb_sys_wr_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        dbg_wr;
   logic [15:0] dbg_waddr, dbg_wdata;
   logic        cpu_req;
   logic [15:0] cpu_waddr, cpu_wdata;
   logic        cpu_gnt;
   logic        mem_wr;
   logic [15:0] mem_waddr, mem_wdata;
   logic        mem_ready;
   logic        ovf_clr;
   logic        dbg_overflow;
   logic [2:0]  dbg_level;
`ifdef SYS_WR_ARB_DROPCNT_EN
   logic [7:0]  drop_count;
`endif

   always #5 sys_clk = ~sys_clk;

   sys_wr_arbiter #(.DEPTH(4), .AW(16), .DW(16)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .dbg_wr       (dbg_wr),
      .dbg_waddr    (dbg_waddr),
      .dbg_wdata    (dbg_wdata),
      .cpu_req      (cpu_req),
      .cpu_waddr    (cpu_waddr),
      .cpu_wdata    (cpu_wdata),
      .cpu_gnt      (cpu_gnt),
      .mem_wr       (mem_wr),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .ovf_clr      (ovf_clr),
      .dbg_overflow (dbg_overflow),
`ifdef SYS_WR_ARB_DROPCNT_EN
      .drop_count   (drop_count),
`endif
      .dbg_level    (dbg_level)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_w;

   typedef struct {
      logic        is_cpu;
      logic [15:0] addr;
      logic [15:0] data;
      logic        exp_gnt;
      logic [2:0]  exp_lvl;
      int          exp_lat;
   } vec_t;

   vec_t vec [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check(name, sb.size(), 0);
   endtask

   // Every completed write must match the next expected entry.
   always @(negedge sys_clk) begin
      if (sys_rst_n && mem_wr && mem_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_write act=%h/%h exp=none", mem_waddr, mem_wdata);
         end else begin
            exp_w = sb.pop_front();
            if ({mem_waddr, mem_wdata} !== exp_w) begin
               bad++;
               $display("FAIL write_order act=%h%h exp=%h", mem_waddr, mem_wdata, exp_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1);
   end

   initial begin
      int lat;
      int cidx;
      logic gnt_seen;

      vec[0] = '{1'b0, 16'h0010, 16'hBEEF, 1'b0, 3'd1, 2};
      vec[1] = '{1'b1, 16'h0020, 16'h1234, 1'b1, 3'd0, 1};
      vec[2] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 3'd1, 2};
      vec[3] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 3'd0, 1};
      vec[4] = '{1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 3'd1, 2};

      sys_rst_n = 1'b0;
      dbg_wr = 1'b0; dbg_waddr = '0; dbg_wdata = '0;
      cpu_req = 1'b1; cpu_waddr = 16'h7777; cpu_wdata = 16'h7777;
      mem_ready = 1'b1; ovf_clr = 1'b0;
      #12;
      check("rst_mem_wr", mem_wr, 0);
      check("rst_addr", mem_waddr, 0);
      check("rst_data", mem_wdata, 0);
      check("rst_ovf", dbg_overflow, 0);
      check("rst_level", dbg_level, 0);
      check("rst_gnt", cpu_gnt, 0);
`ifdef SYS_WR_ARB_DROPCNT_EN
      check("rst_dropcnt", drop_count, 0);
`endif
      cpu_req = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      step();

      // Single isolated writes from either source
      for (int i = 0; i < 5; i++) begin
         if (vec[i].is_cpu) begin
            cpu_req = 1'b1; cpu_waddr = vec[i].addr; cpu_wdata = vec[i].data;
         end else begin
            dbg_wr = 1'b1; dbg_waddr = vec[i].addr; dbg_wdata = vec[i].data;
         end
         sb.push_back({vec[i].addr, vec[i].data});
         #1;
         check($sformatf("vec%0d_gnt", i), cpu_gnt, vec[i].exp_gnt);
         step();
         dbg_wr = 1'b0; cpu_req = 1'b0;
         check($sformatf("vec%0d_level", i), dbg_level, vec[i].exp_lvl);
         lat = 1;
         while (!mem_wr && lat < 8) begin
            step();
            lat++;
         end
         check($sformatf("vec%0d_latency", i), lat, vec[i].exp_lat);
         step();
         check($sformatf("vec%0d_single", i), mem_wr, 0);
      end
      drain("vec_drain");

      // Contention: CPU held continuously against four debug writes
      sb.push_back({16'h0100, 16'hC000});
      sb.push_back({16'h0001, 16'hD001});
      sb.push_back({16'h0101, 16'hC001});
      sb.push_back({16'h0002, 16'hD002});
      sb.push_back({16'h0102, 16'hC002});
      sb.push_back({16'h0003, 16'hD003});
      sb.push_back({16'h0103, 16'hC003});
      sb.push_back({16'h0004, 16'hD004});
      cidx = 0;
      for (int k = 0; k < 8; k++) begin
         dbg_wr    = (k < 4);
         dbg_waddr = 16'(k + 1);
         dbg_wdata = 16'hD000 + 16'(k + 1);
         cpu_req   = (cidx < 4);
         cpu_waddr = 16'h0100 + 16'(cidx);
         cpu_wdata = 16'hC000 + 16'(cidx);
         #1;
         check($sformatf("alt_gnt%0d", k), cpu_gnt, (k % 2 == 0));
         gnt_seen = cpu_gnt;
         step();
         if (gnt_seen && cpu_req) cidx++;
      end
      dbg_wr = 1'b0; cpu_req = 1'b0;
      drain("alt_drain");

      // Slot held by a CPU write; FIFO fills and the fifth write is dropped
      mem_ready = 1'b0;
      cpu_req = 1'b1; cpu_waddr = 16'h0300; cpu_wdata = 16'h3000;
      #1;
      check("hold_first_gnt", cpu_gnt, 1);
      step();
      cpu_waddr = 16'h0301; cpu_wdata = 16'h3001;
      check("hold_mem_wr", mem_wr, 1);
      for (int k = 0; k < 5; k++) begin
         dbg_wr = 1'b1; dbg_waddr = 16'h0401 + 16'(k); dbg_wdata = 16'h4401 + 16'(k);
         #1;
         check($sformatf("hold_gnt%0d", k), cpu_gnt, 0);
         step();
         check($sformatf("hold_addr%0d", k), mem_waddr, 16'h0300);
         check($sformatf("hold_data%0d", k), mem_wdata, 16'h3000);
         check($sformatf("hold_level%0d", k), dbg_level, (k < 4) ? k + 1 : 4);
      end
      dbg_wr = 1'b0;
      check("drop_ovf", dbg_overflow, 1);
`ifdef SYS_WR_ARB_DROPCNT_EN
      check("drop_cnt1", drop_count, 1);
`endif
      dbg_wr = 1'b1; dbg_waddr = 16'h04FF; dbg_wdata = 16'h44FF; ovf_clr = 1'b1;
      step();
      dbg_wr = 1'b0; ovf_clr = 1'b0;
      check("clr_vs_drop_ovf", dbg_overflow, 1);
`ifdef SYS_WR_ARB_DROPCNT_EN
      check("drop_cnt2", drop_count, 2);
`endif
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_cleared", dbg_overflow, 0);

      // Release with FIFO full: debug push alongside the pop, full beats fairness
      sb.push_back({16'h0300, 16'h3000});
      sb.push_back({16'h0401, 16'h4401});
      sb.push_back({16'h0402, 16'h4402});
      sb.push_back({16'h0301, 16'h3001});
      sb.push_back({16'h0403, 16'h4403});
      sb.push_back({16'h0404, 16'h4404});
      sb.push_back({16'h0406, 16'h4406});
      mem_ready = 1'b1;
      dbg_wr = 1'b1; dbg_waddr = 16'h0406; dbg_wdata = 16'h4406;
      #1;
      check("rel0_gnt", cpu_gnt, 0);
      step();
      dbg_wr = 1'b0;
      check("full_pop_push_level", dbg_level, 4);
      check("full_pop_push_ovf", dbg_overflow, 0);
`ifdef SYS_WR_ARB_DROPCNT_EN
      check("full_pop_push_cnt", drop_count, 2);
`endif
      #1;
      check("rel1_gnt_full_prio", cpu_gnt, 0);
      step();
      #1;
      check("rel2_gnt", cpu_gnt, 1);
      step();
      cpu_req = 1'b0;
      drain("rel_drain");

      // Reset in the middle of a held write with three queued entries
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dbg_wr = 1'b1; dbg_waddr = 16'h0501 + 16'(k); dbg_wdata = 16'h5501 + 16'(k);
         step();
      end
      dbg_wr = 1'b0;
      check("pre_rst_mem_wr", mem_wr, 1);
      check("pre_rst_level", dbg_level, 3);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_rst_mem_wr", mem_wr, 0);
      check("async_rst_level", dbg_level, 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      mem_ready = 1'b1;
      repeat (10) step();
      check("post_rst_mem_wr", mem_wr, 0);
      check("post_rst_level", dbg_level, 0);
      check("post_rst_sb", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sys_wr_arbiter.md
# sys_wr_arbiter

Shares the single system write port (the 16-bit address/data write strobe interface) between the UART debug interface and a CPU-side write requester. Debug writes are fire-and-forget, so they are absorbed into a small FIFO. A round-robin arbiter merges the two streams into one registered output slot with valid/ready backpressure toward the memory/peripheral side.

## Interface
Parameters:
- DEPTH, 4: debug FIFO entries; power of 2, minimum 2.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- dbg_wr  in  1  debug write strobe, one cycle per write; cannot be stalled.
- dbg_waddr  in  AW  debug write address, valid with dbg_wr.
- dbg_wdata  in  DW  debug write data, valid with dbg_wr.
- cpu_req  in  1  CPU write request; held with addr/data until granted.
- cpu_waddr  in  AW  CPU write address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  combinational accept; cpu_req & cpu_gnt = transfer.
- mem_wr  out  1  output write valid (registered).
- mem_waddr  out  AW  output address (registered).
- mem_wdata  out  DW  output data (registered).
- mem_ready  in  1  sink accepts; mem_wr & mem_ready = write done.
- ovf_clr  in  1  pulse; clears dbg_overflow.
- dbg_overflow  out  1  sticky; a debug write was dropped.
- dbg_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  saturating dropped-write count (SYS_WR_ARB_DROPCNT_EN only).

## Operation
- Reset values: mem_wr=0, mem_waddr=0, mem_wdata=0, dbg_overflow=0, dbg_level=0, drop_count=0, owner=S_IDLE, last=CPU. FIFO is emptied and cpu_gnt=0.
- Slot free this cycle: free = !mem_wr | mem_ready.
- Owner state machine (owner of the output slot): S_IDLE, S_DBG, S_CPU.
  - When free, the slot loads the selected source and moves to S_DBG or S_CPU.
  - When free and nothing is selected, the slot moves to S_IDLE and mem_wr drops to 0.
- Selection, evaluated only when free:
  - FIFO full (level==DEPTH): select debug. The full FIFO takes priority over fairness.
  - Both FIFO non-empty and cpu_req: select the source opposite `last`.
  - Only one pending: select that source.
  - `last` updates on every load.
- cpu_gnt = free & cpu_req & (CPU selected). It is never asserted while the slot is held (mem_wr & !mem_ready).
- Debug selection pops the FIFO head in the same cycle.
- FIFO push on dbg_wr:
  - Not full: accepted.
  - Full with a pop in the same cycle: accepted (level unchanged).
  - Full without a pop: the write is dropped, dbg_overflow is set next cycle, and drop_count increments, saturating at 255.
- ovf_clr and a drop in the same cycle: the set wins (dbg_overflow stays 1).
- Writes are never reordered within one source. Interleaving between sources is unconstrained beyond round-robin.
- Reset asserted mid-operation: in-flight slot contents and FIFO contents are discarded. There is no partial write (mem_wr goes 0 asynchronously).

## Timing
- Debug write latency, FIFO empty and slot idle: dbg_wr in cycle N, mem_wr=1 in cycle N+2 (push at edge N, pop/load at edge N+1). There is no bypass path.
- CPU latency: cpu_gnt high in cycle N when free; mem_wr=1 in cycle N+1.
- Throughput: with mem_ready tied high, one write per cycle. Under contention, sources alternate 1:1.
- mem_waddr and mem_wdata are stable while mem_wr & !mem_ready.
- dbg_level reflects the registered occupancy (post-edge value).

## Configuration
- SYS_WR_ARB_DROPCNT_EN defined: the drop_count port and its 8-bit saturating counter exist and are reset to 0.
- SYS_WR_ARB_DROPCNT_EN undefined: the port and counter are removed. dbg_overflow behaviour is unchanged.

## Structure
- Package sys_arb_pkg holds:
  - owner_t enum {S_IDLE, S_DBG, S_CPU}.
  - src_t enum {SRC_DBG, SRC_CPU} for `last`.
  - Default AW/DW localparams.
- Sub-module sys_wr_fifo: synchronous FIFO, DEPTH×(AW+DW), push/pop/full/empty/level. Simultaneous push/pop is legal when full or empty.
- Arbiter, owner FSM, output slot, overflow flag and optional counter live in sys_wr_arbiter.

## Test plan
- Single debug write, addr 0x0010 data 0xBEEF, mem_ready=1 -> mem_wr in cycle N+2 with 0x0010/0xBEEF, exactly one cycle.
- CPU req 0x0020/0x1234 while idle -> cpu_gnt same cycle, mem_wr next cycle with 0x0020/0x1234.
- Continuous cpu_req, with debug writes 0x0001..0x0004, mem_ready=1 -> output alternates DBG,CPU,DBG,CPU…; debug order is preserved.
- mem_ready=0 with the slot loaded -> mem_* held constant and cpu_gnt=0; the 5th debug write into DEPTH=4 is dropped, dbg_overflow=1, drop_count=1. A subsequent ovf_clr sets dbg_overflow=0.
- FIFO full, plus a dbg_wr in the same cycle as a pop -> no drop, level stays 4.
- sys_rst_n low mid-hold (mem_wr=1, mem_ready=0, FIFO level 3) -> mem_wr=0 immediately. After release: level 0 and no spurious writes.
